multiword_add_sequencer: RTL and testbench

- Multi-cycle sequencer that performs wide signed/unsigned add or subtract on a single narrow combinational adder instance.
- Feeds the adder one WORD_WIDTH slice per cycle, least significant word first, and consumes its result, carry and overflow.
- Chains the carry across slices and assembles the full-width sum, carry and signed overflow.
- Sits directly around the adder: drives its inputs and captures its outputs. Valid/ready handshake on both the upstream and downstream sides.

---
 rtl/multiword_add_sequencer_if.sv | 31 +++
 rtl/multiword_add_sequencer.sv | 65 ++++++
 tb/tb_multiword_add_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/multiword_add_sequencer_if.sv
// multiword_add_sequencer_if: operand, adder-slice and result handshake bundle
interface multiword_add_sequencer_if #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_WORDS  = 4
);
  localparam int TOTAL_WIDTH = WORD_WIDTH * NUM_WORDS;
  logic                   in_valid;
  logic                   in_ready;
  logic [TOTAL_WIDTH-1:0] op_a;
  logic [TOTAL_WIDTH-1:0] op_b;
  logic                   op_sub;
  logic [WORD_WIDTH-1:0]  add_a;
  logic [WORD_WIDTH-1:0]  add_b;
  logic                   add_cin;
  logic [WORD_WIDTH-1:0]  add_result;
  logic                   add_cout;
  logic                   add_ovf;
  logic                   out_valid;
  logic                   out_ready;
  logic [TOTAL_WIDTH-1:0] sum;
  logic                   carry_out;
  logic                   overflow;
  modport slave (
    input  in_valid, op_a, op_b, op_sub, add_result, add_cout, add_ovf, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, sum, carry_out, overflow
  );
  modport master (
    output in_valid, op_a, op_b, op_sub, add_result, add_cout, add_ovf, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, sum, carry_out, overflow
  );
endinterface

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: wide add/subtract streamed word by word through one narrow adder
module multiword_add_sequencer #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_WORDS  = 4
) (
  input logic clk,
  input logic rst,
  multiword_add_sequencer_if.slave bus
);
  localparam int TOTAL_WIDTH = WORD_WIDTH * NUM_WORDS;
  localparam int IW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]             state;
  logic [TOTAL_WIDTH-1:0] a_q;
  logic [TOTAL_WIDTH-1:0] b_q;
  logic [TOTAL_WIDTH-1:0] sum_q;
  logic                   c_q;
  logic                   cout_q;
  logic                   ovf_q;
  logic [IW-1:0]          idx;
  logic                   running;
  logic                   last;
  assign running       = state == RUN;
  assign last          = idx == IW'(NUM_WORDS - 1);
  assign bus.in_ready  = state == IDLE && !rst;
  assign bus.out_valid = state == DONE;
  assign bus.add_a     = running ? a_q[idx*WORD_WIDTH +: WORD_WIDTH] : '0;
  assign bus.add_b     = running ? b_q[idx*WORD_WIDTH +: WORD_WIDTH] : '0;
  assign bus.add_cin   = running ? c_q : 1'b0;
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
  // Capture operands (B pre-inverted for subtract), walk the slices LSW first, then hold the result until taken
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      idx    <= '0;
    end else if (state == IDLE) begin
      if (bus.in_valid) begin
        a_q   <= bus.op_a;
        b_q   <= bus.op_sub ? ~bus.op_b : bus.op_b;
        c_q   <= bus.op_sub;
        idx   <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      sum_q[idx*WORD_WIDTH +: WORD_WIDTH] <= bus.add_result;
      c_q <= bus.add_cout;
      if (last) begin
        cout_q <= bus.add_cout;
        ovf_q  <= bus.add_ovf;
        state  <= DONE;
      end else
        idx <= idx + 1'b1;
    end else if (bus.out_ready)
      state <= IDLE;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb_multiword_add_sequencer: table-driven check of the wide add/sub sequencer with a behavioural 32-bit adder
module tb_multiword_add_sequencer;
  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic         sub;
    logic [127:0] s;
    logic         c;
    logic         v;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int passed = 0;
  vec_t vecs[8];
  logic [32:0] full;
  multiword_add_sequencer_if #(.WORD_WIDTH(32), .NUM_WORDS(4)) bus();
  multiword_add_sequencer #(.WORD_WIDTH(32), .NUM_WORDS(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign full           = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'b0, bus.add_cin};
  assign bus.add_result = full[31:0];
  assign bus.add_cout   = full[32];
  assign bus.add_ovf    = (bus.add_a[31] == bus.add_b[31]) && (full[31] != bus.add_a[31]);
  task automatic checkw(input string n, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask
  task automatic check1(input string n, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", n, act, exp);
  endtask
  task automatic start(input vec_t v);
    int n;
    logic busy_ok;
    @(negedge clk);
    check1("in_ready_idle", bus.in_ready, 1'b1);
    bus.op_a = v.a;
    bus.op_b = v.b;
    bus.op_sub = v.sub;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.op_a = ~v.a;
    bus.op_b = ~v.b;
    bus.op_sub = ~v.sub;
    check1("cin_first", bus.add_cin, v.sub);
    n = 0;
    busy_ok = 1'b1;
    while (!bus.out_valid && n < 20) begin
      busy_ok &= !bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    checkw("latency", 128'(n), 128'd4);
    check1("busy_in_ready_low", busy_ok, 1'b1);
    checkw("sum", bus.sum, v.s);
    check1("carry_out", bus.carry_out, v.c);
    check1("overflow", bus.overflow, v.v);
  endtask
  task automatic finish_op;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check1("release_out_valid", bus.out_valid, 1'b0);
    check1("release_in_ready", bus.in_ready, 1'b1);
  endtask
  initial begin
    logic [127:0] held_sum;
    logic held_c, held_v, stable;
    vecs[0] = '{128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0, 128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[1] = '{{4{32'hFFFF_FFFF}}, 128'd1, 1'b0, 128'd0, 1'b1, 1'b0};
    vecs[2] = '{{32'h7FFF_FFFF, {3{32'hFFFF_FFFF}}}, 128'd1, 1'b0, {32'h8000_0000, 96'd0}, 1'b0, 1'b1};
    vecs[3] = '{128'd5, 128'd7, 1'b1, {{3{32'hFFFF_FFFF}}, 32'hFFFF_FFFE}, 1'b0, 1'b0};
    vecs[4] = '{128'd7, 128'd5, 1'b1, 128'd2, 1'b1, 1'b0};
    vecs[5] = '{{32'h8000_0000, 96'd0}, 128'd1, 1'b1, {32'h7FFF_FFFF, {3{32'hFFFF_FFFF}}}, 1'b1, 1'b1};
    vecs[6] = '{128'd1, 128'd1, 1'b0, 128'd2, 1'b0, 1'b0};
    vecs[7] = '{128'h1234_5678_0000_0000_0000_0000_0000_0000, 128'h1234_5678_0000_0000_0000_0000_0000_0000, 1'b1, 128'd0, 1'b1, 1'b0};
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.op_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1("reset_in_ready", bus.in_ready, 1'b0);
    check1("reset_out_valid", bus.out_valid, 1'b0);
    checkw("reset_sum", bus.sum, 128'd0);
    check1("reset_carry", bus.carry_out, 1'b0);
    check1("reset_ovf", bus.overflow, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkw("idle_add_a", 128'(bus.add_a), 128'd0);
    check1("idle_add_cin", bus.add_cin, 1'b0);
    for (int i = 0; i < 8; i++) begin
      start(vecs[i]);
      finish_op();
    end
    start(vecs[2]);
    held_sum = bus.sum;
    held_c = bus.carry_out;
    held_v = bus.overflow;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = i[0];
      bus.op_a = 128'(i) * 128'h0101_0101;
      @(posedge clk);
      #1;
      stable &= bus.sum === held_sum && bus.carry_out === held_c && bus.overflow === held_v;
      stable &= bus.out_valid && !bus.in_ready;
    end
    bus.in_valid = 1'b0;
    check1("backpressure_stable", stable, 1'b1);
    finish_op();
    start(vecs[4]);
    finish_op();
    @(negedge clk);
    bus.op_a = {4{32'h1111_1111}};
    bus.op_b = {4{32'h1111_1111}};
    bus.op_sub = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check1("abort_out_valid", bus.out_valid, 1'b0);
    checkw("abort_sum", bus.sum, 128'd0);
    check1("abort_carry", bus.carry_out, 1'b0);
    check1("abort_ovf", bus.overflow, 1'b0);
    check1("abort_in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check1("post_reset_in_ready", bus.in_ready, 1'b1);
    start(vecs[6]);
    finish_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
